// File: rtl/mem_dump_reader.sv
// mem_dump_reader
// Debug-side initiator for the core's read-only data-memory inspection port.
// A start request sweeps a word-aligned address range. Each returned word is
// captured RD_LAT cycles after its address was presented, then buffered with
// its address and a last flag in a small FIFO. The FIFO drains on a
// valid/ready stream.
// Issue is credit-gated: a new address is only presented when the words
// already buffered plus the words still in flight leave room for it. The push
// that lands RD_LAT cycles later therefore never finds the FIFO full.

module mem_dump_reader #(
    parameter int XLEN   = 32,   // data/address width (riscv_pkg XLEN)
    parameter int RD_LAT = 1,    // 0 or 1 cycles from addr_o to data_i
    parameter int DEPTH  = 4,    // output FIFO depth, power of 2, >= RD_LAT+2
    parameter int CNT_W  = 16    // word count width
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [XLEN-1:0]  base_addr_i,
    input  logic [CNT_W-1:0] word_cnt_i,
    output logic [XLEN-1:0]  addr_o,
    input  logic [XLEN-1:0]  data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [XLEN-1:0]  m_data_o,
    output logic [XLEN-1:0]  m_addr_o,
    output logic             m_last_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_CW_C   = CW'(1);
    localparam logic [CNT_W-1:0] ONE_CNT_C = CNT_W'(1);
    localparam logic [XLEN-1:0] WORD_INC_C = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_C    = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [AW-1:0]   ONE_AW_C   = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_r;
    state_t stateNext_s;

    // Sweep datapath
    logic [XLEN-1:0]  addr_r;
    logic [CNT_W-1:0] remCnt_r;
    logic             cntNonZero_s;
    logic             startAccept_s;
    logic [XLEN-1:0]  alignedBase_s;

    // Issue / capture handshake
    logic             issue_s;
    logic             lastIssue_s;
    logic             inflight_s;
    logic             push_s;
    logic [XLEN-1:0]  pushAddr_s;
    logic             pushLast_s;
    logic [CW-1:0]    credit_s;

    // Output FIFO
    logic [XLEN-1:0]  fifoData_r [DEPTH];
    logic [XLEN-1:0]  fifoAddr_r [DEPTH];
    logic             fifoLast_r [DEPTH];
    logic [AW-1:0]    wrPtr_r;
    logic [AW-1:0]    rdPtr_r;
    logic [CW-1:0]    fifoCount_r;
    logic             fifoFull_s;
    logic             headValid_s;
    logic             headLast_s;
    logic             pop_s;
    logic             drainDone_s;

    // Request decode, alignment and credit check
    always_comb begin
        cntNonZero_s  = (word_cnt_i != {CNT_W{1'b0}});
        startAccept_s = (state_r == IDLE) && start_i && cntNonZero_s;
        alignedBase_s = base_addr_i & ALIGN_C;
        credit_s      = fifoCount_r + {{(CW-1){1'b0}}, inflight_s};
        issue_s       = (state_r == ISSUE) && (credit_s < DEPTH_C);
        lastIssue_s   = issue_s && (remCnt_r == ONE_CNT_C);
        headValid_s   = (fifoCount_r != {CW{1'b0}});
        fifoFull_s    = (fifoCount_r == DEPTH_C);
        headLast_s    = fifoLast_r[rdPtr_r];
        pop_s         = headValid_s && m_ready_i;
        // The final beat leaving with nothing behind it ends the dump
        drainDone_s   = (inflight_s == 1'b0) && pop_s && headLast_s &&
                        (fifoCount_r == ONE_CW_C);
    end

    generate
        if (RD_LAT == 0) begin : gLat0
            // Zero-latency port: capture the word in its own issue cycle
            always_comb begin
                push_s     = issue_s;
                pushAddr_s = addr_r;
                pushLast_s = lastIssue_s;
                inflight_s = 1'b0;
            end
        end else begin : gLat1
            logic            pendValid_r;
            logic [XLEN-1:0] pendAddr_r;
            logic            pendLast_r;

            // Remember what was issued last cycle so its data can be paired up
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    pendValid_r <= 1'b0;
                    pendAddr_r  <= {XLEN{1'b0}};
                    pendLast_r  <= 1'b0;
                end else begin
                    pendValid_r <= issue_s;
                    pendAddr_r  <= addr_r;
                    pendLast_r  <= lastIssue_s;
                end
            end

            // One-cycle port: data_i now belongs to last cycle's address
            always_comb begin
                push_s     = pendValid_r;
                pushAddr_s = pendAddr_r;
                pushLast_s = pendLast_r;
                inflight_s = pendValid_r;
            end
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if (cntNonZero_s) begin
                        stateNext_s = ISSUE;
                    end else begin
                        stateNext_s = DONE;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            ISSUE: begin
                if (lastIssue_s) begin
                    stateNext_s = DRAIN;
                end else begin
                    stateNext_s = ISSUE;
                end
            end
            DRAIN: begin
                if (drainDone_s) begin
                    stateNext_s = DONE;
                end else begin
                    stateNext_s = DRAIN;
                end
            end
            DONE:    stateNext_s = IDLE;
            default: stateNext_s = IDLE;
        endcase
    end

    // FSM outputs and stream head presentation
    always_comb begin
        busy_o    = (state_r == ISSUE) || (state_r == DRAIN);
        done_o    = (state_r == DONE);
        addr_o    = addr_r;
        m_valid_o = headValid_s;
        if (headValid_s) begin
            m_data_o = fifoData_r[rdPtr_r];
            m_addr_o = fifoAddr_r[rdPtr_r];
            m_last_o = headLast_s;
        end else begin
            m_data_o = {XLEN{1'b0}};
            m_addr_o = {XLEN{1'b0}};
            m_last_o = 1'b0;
        end
    end

    // Sweep address and remaining-word counter; wraps modulo 2^XLEN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_r   <= {XLEN{1'b0}};
            remCnt_r <= {CNT_W{1'b0}};
        end else if (startAccept_s) begin
            addr_r   <= alignedBase_s;
            remCnt_r <= word_cnt_i;
        end else if (issue_s) begin
            addr_r   <= addr_r + WORD_INC_C;
            remCnt_r <= remCnt_r - ONE_CNT_C;
        end else begin
            addr_r   <= addr_r;
            remCnt_r <= remCnt_r;
        end
    end

    // FIFO storage: write captured word, address and last flag at the tail
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifoData_r[i] <= {XLEN{1'b0}};
                fifoAddr_r[i] <= {XLEN{1'b0}};
                fifoLast_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            fifoData_r[wrPtr_r] <= data_i;
            fifoAddr_r[wrPtr_r] <= pushAddr_s;
            fifoLast_r[wrPtr_r] <= pushLast_s;
        end else begin
            fifoData_r[wrPtr_r] <= fifoData_r[wrPtr_r];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wrPtr_r     <= {AW{1'b0}};
            rdPtr_r     <= {AW{1'b0}};
            fifoCount_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + ONE_AW_C;
            end else begin
                wrPtr_r <= wrPtr_r;
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + ONE_AW_C;
            end else begin
                rdPtr_r <= rdPtr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifoCount_r <= fifoCount_r + ONE_CW_C;
                2'b01:   fifoCount_r <= fifoCount_r - ONE_CW_C;
                default: fifoCount_r <= fifoCount_r;
            endcase
        end
    end

    mem_dump_reader_chk #(
        .XLEN (XLEN),
        .CW   (CW),
        .DEPTH(DEPTH)
    ) uChk (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .push_i    (push_s),
        .full_i    (fifoFull_s),
        .credit_i  (credit_s),
        .mValid_i  (m_valid_o),
        .mReady_i  (m_ready_i),
        .mData_i   (m_data_o),
        .mAddr_i   (m_addr_o),
        .mLast_i   (m_last_o)
    );

endmodule

// mem_dump_reader_chk
// Protocol and credit invariants of mem_dump_reader.
module mem_dump_reader_chk #(
    parameter int XLEN  = 32,
    parameter int CW    = 3,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            push_i,
    input  logic            full_i,
    input  logic [CW-1:0]   credit_i,
    input  logic            mValid_i,
    input  logic            mReady_i,
    input  logic [XLEN-1:0] mData_i,
    input  logic [XLEN-1:0] mAddr_i,
    input  logic            mLast_i
);

    // A capture must never land on a full FIFO
    aPushNotFull: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(push_i && full_i));

    // Buffered plus in-flight words never exceed the FIFO depth
    aCreditBound: assert property (@(posedge clk_i) disable iff (!rstn_i)
        credit_i <= CW'(DEPTH));

    // A stalled head beat holds all of its fields
    aHeadStable: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (mValid_i && !mReady_i) |=> (mValid_i && $stable(mData_i) &&
                                     $stable(mAddr_i) && $stable(mLast_i)));

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Debug-side reader for the core's data-memory inspection port. On a start request it sweeps a word-aligned address range by driving the core's `addr_i`, captures the returned `data_o` after a fixed read latency, and buffers each word in a small FIFO. Words leave on a valid/ready stream toward the testbench or host link. It sits outside `core_model` and is the initiator for the core's read-only inspection port.

## Interface
- `XLEN`, 32 (from `riscv_pkg`): data and address width.
- `RD_LAT`, 1: cycles from `addr_o` presented to `data_i` valid. Legal values are 0 or 1.
- `DEPTH`, 4: output FIFO depth. Power of 2, at least `RD_LAT`+2.
- `CNT_W`, 16: width of the word count.

- `clk_i` in 1: the single clock.
- `rstn_i` in 1: asynchronous reset, active-low.
- `start_i` in 1: start request. Sampled only in IDLE.
- `base_addr_i` in XLEN: byte address of the first word. Bits [1:0] are ignored (treated as 0).
- `word_cnt_i` in CNT_W: number of words to read. 0 is legal.
- `addr_o` out XLEN: to the core's `addr_i`.
- `data_i` in XLEN: from the core's `data_o`.
- `m_valid_o` out 1: stream beat valid.
- `m_ready_i` in 1: stream beat accepted.
- `m_data_o` out XLEN: captured word.
- `m_addr_o` out XLEN: address the word was read from.
- `m_last_o` out 1: final beat of the dump.
- `busy_o` out 1: dump in progress.
- `done_o` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start_i`=1 with `word_cnt_i`≠0: latch base (low 2 bits cleared) and count, go to ISSUE.
  - `start_i`=1 with `word_cnt_i`=0: go to DONE.
- ISSUE:
  - An issue happens in a cycle when `fifo_count + inflight < DEPTH`. `fifo_count` is the value at the start of the cycle; a same-cycle pop gets no credit.
  - On issue: the current `addr_o` is read, `addr_o` advances by 4 at the clock edge, and the remaining count decrements.
  - When no issue happens, `addr_o` holds its value.
  - After the last issue, go to DRAIN.
- Capture: `data_i` is sampled `RD_LAT` cycles after its issue cycle (same cycle when `RD_LAT`=0). It is pushed with its address and a last flag. The last flag is set only on the final issued word.
  - Credit accounting must guarantee the push never finds the FIFO full. A push into a full FIFO is a design error; flag it with an assertion.
- DRAIN: wait until inflight=0, the FIFO is empty, and the last beat has handshaked, then go to DONE.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- Stream rules:
  - `m_valid_o` = FIFO not empty.
  - `m_data_o`, `m_addr_o` and `m_last_o` come from the FIFO head.
  - A handshake is `m_valid_o & m_ready_i`. It pops the head.
  - Head fields must stay stable while `m_valid_o & !m_ready_i`.
- Address arithmetic is modulo 2^XLEN: 0xFFFF_FFFC + 4 = 0x0000_0000, with no error.
- `start_i` outside IDLE is ignored. It is neither queued nor allowed to alter the latched base or count.
- `busy_o` = 1 in ISSUE and DRAIN only.
- Reset (asynchronous, at any time including mid-dump):
  - State goes to IDLE; FIFO pointers, count and inflight clear.
  - `addr_o`=0, `m_valid_o`=0, `m_last_o`=0, `busy_o`=0, `done_o`=0.
  - `m_data_o` and `m_addr_o` read as 0.
  - Words in flight are discarded.

## Timing
- The cycle in which `start_i` is sampled is cycle 0. `addr_o` = base in cycle 1, which is the first issue.
- First `m_valid_o`: cycle 2 for `RD_LAT`=0; cycle 3 for `RD_LAT`=1.
- With `m_ready_i` held at 1: one beat per cycle, no bubbles.
- `done_o` is high in the cycle after the final handshake cycle. `busy_o` drops in that same cycle.
- `word_cnt_i`=0: `done_o` in cycle 1; no beats are produced and `busy_o` never rises.
- Back-to-back dumps: a new `start_i` is accepted in the IDLE cycle after DONE, with no extra gap.

## Test plan
- Basic dump, `RD_LAT`=1: base 0x100, count 4, ready held at 1.
  - Beats `m_addr_o` = 0x100/104/108/10C in cycles 3–6, `m_data_o` = the memory contents, `m_last_o` only on 0x10C.
  - `done_o` in cycle 7.
- Backpressure: same dump, `m_ready_i` low in cycles 3–8.
  - Head holds 0x100 stable throughout; at most `DEPTH` words are issued and `addr_o` stalls at 0x110.
  - After ready rises, all 4 beats arrive in order with no loss or duplication.
- Zero count and misaligned base: count 0 → `done_o` in cycle 1 and no `m_valid_o`. Base 0x203 with count 1 → single beat with `m_addr_o`=0x200 and `m_last_o`=1.
- Wrap-around: base 0xFFFF_FFF8, count 4 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- Reset mid-dump: assert `rstn_i`=0 after 2 handshakes of a 16-word dump.
  - All outputs read 0 immediately, without waiting for a clock edge.
  - A fresh dump after reset produces exactly its own words.
- Start while busy: pulse `start_i` with a different base during ISSUE and during DRAIN → ignored, and the original dump completes with the original beat count.
